// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// holds the fetched word in an output register until decode accepts it.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst,
  input  logic            inst_ready,
  output logic            misalign_err
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            drop_q, drop_d;
  logic            inst_valid_q, inst_valid_d;
  logic            misalign_q, misalign_d;
  logic            redir_ok, redir_bad, req_fire;

  assign redir_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);

  // Any redirect, even a rejected misaligned one, suppresses issue that cycle.
  assign imem_req_valid = (state_q == ST_REQ) & ~stall & ~redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign inst_valid   = inst_valid_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign misalign_err = misalign_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    misalign_d   = redir_bad;

    if (redir_ok) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      drop_d       = 1'b0;
      state_d      = ST_REQ;
      // An outstanding response must be swallowed unless it is arriving now.
      if ((state_q == ST_WAIT) && !imem_resp_valid) begin
        drop_d  = 1'b1;
        state_d = ST_WAIT;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (req_fire) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else begin
              inst_d       = imem_resp_data;
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
              state_d      = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (inst_valid_q && inst_ready) begin
            pc_d         = pc_q + XLEN'(4);
            inst_valid_d = 1'b0;
            state_d      = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus
// randomized traffic checked each cycle against a transaction-level model.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redirect_valid, imem_req_ready, imem_resp_valid, inst_ready;
  logic [31:0] redirect_pc, imem_resp_data;
  logic        imem_req_valid, inst_valid, misalign_err;
  logic [31:0] imem_req_addr, inst_pc, inst;

  logic        w_rst, w_stall, w_redir, w_mready, w_resp_valid, w_iready;
  logic [31:0] w_rpc, w_resp_data;
  logic        w_req_valid, w_inst_valid, w_mis;
  logic [31:0] w_req_addr, w_inst_pc, w_inst;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
    .inst_pc(inst_pc), .inst(inst), .inst_ready(inst_ready),
    .misalign_err(misalign_err)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(w_rst), .stall(w_stall),
    .redirect_valid(w_redir), .redirect_pc(w_rpc),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(w_mready), .imem_resp_valid(w_resp_valid),
    .imem_resp_data(w_resp_data), .inst_valid(w_inst_valid),
    .inst_pc(w_inst_pc), .inst(w_inst), .inst_ready(w_iready),
    .misalign_err(w_mis)
  );

  int checks = 0;
  int errors = 0;

  // stimulus knobs for the next cycle
  bit          d_stall, d_redir, d_iready, d_mready;
  logic [31:0] d_rpc;
  int          d_delay;

  // memory: one pending response with a countdown
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;

  // reference model: pc, request in flight, output occupied, response to discard
  logic [31:0] m_pc, m_inst, m_ipc;
  bit          m_busy, m_full, m_drop, m_mis, exp_req, aligned;

  int          rise[3];
  logic [31:0] got_i[3], got_p[3];
  int          nrise, cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_busy = 0; m_full = 0; m_drop = 0; m_mis = 0;
    m_inst = 0; m_ipc = 0; mem_pend = 0; mem_cnt = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (mem_pend && mem_cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_addr ^ 32'hDEAD_0000;
      mem_pend        = 0;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mem_pend) mem_cnt--;
    end
    stall = d_stall; redirect_valid = d_redir; redirect_pc = d_rpc;
    inst_ready = d_iready; imem_req_ready = d_mready;
    #1;
    exp_req = !m_busy && !m_full && !d_stall && !d_redir;
    chk("req_valid", imem_req_valid, exp_req);
    if (exp_req) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", inst_valid, m_full);
    if (m_full) begin
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_ipc);
    end
    chk("misalign_err", misalign_err, m_mis);
    if (imem_req_valid && imem_req_ready) begin
      mem_pend = 1; mem_addr = imem_req_addr; mem_cnt = d_delay;
    end
    aligned = d_redir && (d_rpc[1:0] == 2'b00);
    m_mis   = d_redir && (d_rpc[1:0] != 2'b00);
    if (aligned) begin
      m_pc = d_rpc; m_full = 0;
      if (m_busy) begin
        if (imem_resp_valid) begin m_busy = 0; m_drop = 0; end
        else m_drop = 1;
      end
    end else if (!m_busy && !m_full) begin
      if (exp_req && d_mready) m_busy = 1;
    end else if (m_busy) begin
      if (imem_resp_valid) begin
        m_busy = 0;
        if (m_drop) m_drop = 0;
        else begin m_full = 1; m_inst = imem_resp_data; m_ipc = m_pc; end
      end
    end else if (d_iready) begin
      m_full = 0; m_pc = m_pc + 32'd4;
    end
    cyc++;
  endtask

  task automatic wait_inst(input string nm);
    int n = 0;
    do begin cycle(); n++; end while (!inst_valid && n < 30);
    chk(nm, inst_valid, 1'b1);
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    do begin cycle(); n++; end while (!imem_req_valid && n < 30);
    chk(nm, imem_req_valid, 1'b1);
  endtask

  // asserted between edges; outputs must clear without waiting for a clock
  task automatic async_reset();
    #2;
    d_stall = 1; stall = 1; d_redir = 0; redirect_valid = 0;
    imem_resp_valid = 0;
    rst = 1;
    #1;
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_misalign", misalign_err, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; stall = 1; redirect_valid = 0; redirect_pc = 0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0; inst_ready = 0;
    w_rst = 1; w_stall = 1; w_redir = 0; w_rpc = 0; w_mready = 0;
    w_resp_valid = 0; w_resp_data = 0; w_iready = 0;
    d_stall = 1; d_redir = 0; d_rpc = 0; d_iready = 1; d_mready = 1; d_delay = 0;
    cyc = 0; nrise = 0;
    for (int i = 0; i < 3; i++) begin rise[i] = -1; got_i[i] = 0; got_p[i] = 0; end
    model_reset();
    #1;
    chk("reset_inst_valid", inst_valid, 1'b0);
    chk("reset_inst", inst, 32'h0);
    chk("reset_inst_pc", inst_pc, 32'h0);
    chk("reset_misalign", misalign_err, 1'b0);

    // wrap instance: stalled for two cycles, then 0xFFFFFFFC followed by 0x0
    @(negedge clk);
    w_rst = 0; w_mready = 1; w_iready = 1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("wrap_stall_req", w_req_valid, 1'b0);
    end
    @(negedge clk); w_stall = 0; #1;
    chk("wrap_req_valid0", w_req_valid, 1'b1);
    chk("wrap_req_addr0", w_req_addr, 32'hFFFF_FFFC);
    @(negedge clk); w_resp_valid = 1; w_resp_data = 32'h2152_FFFC; #1;
    chk("wrap_req_wait", w_req_valid, 1'b0);
    @(negedge clk); w_resp_valid = 0; #1;
    chk("wrap_inst_valid", w_inst_valid, 1'b1);
    chk("wrap_inst_pc", w_inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", w_inst, 32'h2152_FFFC);
    @(negedge clk); #1;
    chk("wrap_req_valid1", w_req_valid, 1'b1);
    chk("wrap_req_addr1", w_req_addr, 32'h0);
    w_stall = 1;

    // zero-wait memory, decode always ready
    @(negedge clk); rst = 0;
    d_stall = 0; d_iready = 1; d_mready = 1; d_delay = 0;
    for (int c = 0; c < 9; c++) begin
      cycle();
      if (c == 0) begin
        chk("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, 32'h0);
      end
      if (inst_valid && nrise < 3) begin
        rise[nrise] = c; got_i[nrise] = inst; got_p[nrise] = inst_pc; nrise++;
      end
    end
    chk("stream_count", nrise, 3);
    chk("stream_inst0", got_i[0], 32'hDEAD_0000);
    chk("stream_pc0", got_p[0], 32'h0);
    chk("stream_inst1", got_i[1], 32'hDEAD_0004);
    chk("stream_pc1", got_p[1], 32'h4);
    chk("stream_inst2", got_i[2], 32'hDEAD_0008);
    chk("stream_pc2", got_p[2], 32'h8);
    chk("stream_rise0", rise[0], 2);
    chk("stream_rise1", rise[1], 5);
    chk("stream_rise2", rise[2], 8);

    // backpressure on 0xC for five cycles
    d_iready = 0;
    wait_inst("bp_timeout");
    repeat (5) begin
      cycle();
      chk("bp_inst_valid", inst_valid, 1'b1);
      chk("bp_inst", inst, 32'hDEAD_000C);
      chk("bp_inst_pc", inst_pc, 32'hC);
      chk("bp_req_valid", imem_req_valid, 1'b0);
    end
    d_iready = 1;
    cycle();
    d_delay = 3;
    cycle();
    chk("bp_next_req_valid", imem_req_valid, 1'b1);
    chk("bp_next_req_addr", imem_req_addr, 32'h10);

    // reset while the 0x10 response is still pending
    cycle();
    async_reset();
    d_stall = 0; d_delay = 0; d_iready = 1;
    cycle();
    chk("restart_req_valid", imem_req_valid, 1'b1);
    chk("restart_req_addr", imem_req_addr, 32'h0);
    wait_inst("restart_inst_timeout");
    chk("restart_inst_pc", inst_pc, 32'h0);
    chk("restart_inst", inst, 32'hDEAD_0000);
    wait_inst("restart_inst4_timeout");
    chk("restart_inst4_pc", inst_pc, 32'h4);

    // redirect while 0x8 is outstanding with a slow response
    d_delay = 3;
    cycle();
    chk("wait_req_addr8", imem_req_addr, 32'h8);
    d_redir = 1; d_rpc = 32'h100;
    cycle();
    d_redir = 0; d_delay = 0; d_iready = 0;
    wait_req("redir_req_timeout");
    chk("redir_req_addr", imem_req_addr, 32'h100);
    wait_inst("redir_inst_timeout");
    chk("redir_inst_pc", inst_pc, 32'h100);
    chk("redir_inst", inst, 32'hDEAD_0100);

    // misaligned redirect while holding 0x100
    d_redir = 1; d_rpc = 32'h102;
    cycle();
    d_redir = 0;
    cycle();
    chk("mis_pulse", misalign_err, 1'b1);
    chk("mis_inst_valid", inst_valid, 1'b1);
    chk("mis_inst_pc", inst_pc, 32'h100);
    cycle();
    chk("mis_pulse_end", misalign_err, 1'b0);
    d_iready = 1;
    cycle();
    cycle();
    chk("mis_next_req_valid", imem_req_valid, 1'b1);
    chk("mis_next_req_addr", imem_req_addr, 32'h104);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      d_stall  = ($urandom_range(0, 3) == 0);
      d_iready = ($urandom_range(0, 9) < 7);
      d_mready = ($urandom_range(0, 9) < 6);
      d_delay  = $urandom_range(0, 3);
      d_redir  = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 9) == 0) d_rpc = 32'hFFFF_FFF0 | ($urandom_range(0, 15));
      else d_rpc = $urandom_range(0, 1023);
      if ($urandom_range(0, 9) < 7) d_rpc = d_rpc & 32'hFFFF_FFFC;
      if (i == 1500) async_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
